// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) arithmetic, affine constants and FSM encoding for the AES S-box engines.
// Pure declarations; no state, no handshake.
package aes_gf_pkg;

    localparam logic [7:0] GF_RED_CONST = 8'h1B;
    localparam logic [7:0] AFF_C        = 8'h63;
    localparam logic [7:0] INV_AFF_C    = 8'h05;
    localparam int         INV_STEPS    = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 as the multiplicand overflows.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_RED_CONST : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ AFF_C;
    endfunction

endpackage

// File: rtl/inv_affine_transform.sv
// Inverse AES affine transform on one byte, mapping the SubBytes domain back to field elements.
// Combinational, zero latency; no handshake.
// No backpressure.
module inv_affine_transform
    import aes_gf_pkg::*;
(
    input  logic [7:0] s,
    output logic [7:0] b
);

    assign b = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ INV_AFF_C;

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative InvSubBytes on LANES bytes: inverse affine then x^254 with one GF multiplier per lane.
// Latency: out_valid 13 cycles after accept; one word per 15 cycles at full rate.
// Backpressure: result held in DONE until out_ready; no input accepted until the next cycle.
// Optional INV_SBOX_FWD_EN adds in_fwd to select forward SubBytes per word.
module inv_sub_bytes_seq
    import aes_gf_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
`ifdef INV_SBOX_FWD_EN
    input  logic               in_fwd,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data
);

    localparam logic [3:0] LAST_STEP = 4'(INV_STEPS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] step;
    logic       accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= 4'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                step <= 4'd0;
            else if (state == MUL)
                step <= (step == LAST_STEP) ? 4'd0 : step + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                if (step == LAST_STEP) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef INV_SBOX_FWD_EN
    logic mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mode <= 1'b0;
        else if (accept)
            mode <= in_fwd;
    end
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] in_byte;
        logic [7:0] inv_b;
        logic [7:0] base_sel;
        logic [7:0] acc;
        logic [7:0] base;
        logic [7:0] mul_res;
        logic [7:0] res;

        assign in_byte = in_data[8*i +: 8];

        inv_affine_transform u_inv_aff (
            .s (in_byte),
            .b (inv_b)
        );

`ifdef INV_SBOX_FWD_EN
        assign base_sel = in_fwd ? in_byte : inv_b;
        assign res      = mode ? affine(acc) : acc;
`else
        assign base_sel = inv_b;
        assign res      = acc;
`endif

        // Even steps square, odd steps multiply by the original element: x^2, x^3, x^6, x^7 ... x^254.
        assign mul_res = gf_mul(acc, step[0] ? base : acc);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc  <= 8'h00;
                base <= 8'h00;
            end else if (accept) begin
                acc  <= base_sel;
                base <= base_sel;
            end else if (state == MUL) begin
                acc  <= mul_res;
            end
        end

        assign out_data[8*i +: 8] = (state == DONE) ? res : 8'h00;
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Scoreboarded bench for inv_sub_bytes_seq: directed vectors, backpressure, reset, exhaustive table sweep.
module tb_inv_sub_bytes_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        in_fwd = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] d;
        int          acc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    bit   head_seen = 1'b0;

    logic [7:0] inv_tab [0:255] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    inv_sub_bytes_seq #(.LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef INV_SBOX_FWD_EN
        .in_fwd    (in_fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] inv_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = inv_tab[w[8*i +: 8]];
        return r;
    endfunction

    function void check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    // Monitor: latency on first sight of each result, data on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            head_seen = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h required no output", out_data);
            end else begin
                if (!head_seen) begin
                    check({exp_q[0].tag, "_latency"}, 32'(cyc - exp_q[0].acc), 32'd13);
                    head_seen = 1'b1;
                end
                if (out_ready) begin
                    check(exp_q[0].tag, out_data, exp_q[0].d);
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic f, input logic [31:0] e,
                        input string tag, output int a);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_fwd   = f;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: in_ready=%b required 1 within 200 cycles", tag, in_ready);
            in_valid = 1'b0;
            a = -1;
        end else begin
            @(posedge clk);
            #1;
            a = cyc;
            exp_q.push_back('{d: e, acc: a, tag: tag});
            in_valid = 1'b0;
            in_fwd   = ~f;
            in_data  = $urandom;
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int a;
        int prev;
        int t;
        logic [31:0] w;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        rst_n = 1'b1;

        send(32'h637C16ED, 1'b0, 32'h0001FF53, "vec1", a);
        send(32'h00000000, 1'b0, 32'h52525252, "zeros", a);
        send(32'h63636363, 1'b0, 32'h00000000, "byte63", a);
        drain("directed");

        // Backpressure: result must hold while a stray input pulse is ignored.
        out_ready = 1'b0;
        send(32'h0052097C, 1'b0, 32'h52484001, "bp", a);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", out_data, 32'h52484001);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            if (k == 1) begin
                in_valid = 1'b1;
                in_data  = 32'hDEADBEEF;
            end
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("bp_no_capture_ready", 32'(in_ready), 32'd1);
        check("bp_no_capture_valid", 32'(out_valid), 32'd0);
        drain("bp");

        // Reset in the middle of the multiply chain discards the word.
        send(32'h11223344, 1'b0, inv_word(32'h11223344), "pre_reset", a);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", out_data, 32'h0);
        rst_n = 1'b1;
        send(32'h7C7C7C7C, 1'b0, 32'h01010101, "post_reset", a);
        drain("reset");

        // Every byte value on every lane, back to back.
        prev = 0;
        for (int n = 0; n < 256; n++) begin
            w = {8'(n + 192), 8'(n + 128), 8'(n + 64), 8'(n)};
            send(w, 1'b0, inv_word(w), "sweep", a);
            if (n > 0) check("sweep_period", 32'(a - prev), 32'd15);
            prev = a;
        end
        drain("sweep");

`ifdef INV_SBOX_FWD_EN
        send(32'h00015300, 1'b1, 32'h637CED63, "fwd", a);
        send(32'h637C16ED, 1'b0, 32'h0001FF53, "inv_after_fwd", a);
        send(32'h00000000, 1'b1, 32'h63636363, "fwd_zero", a);
        send(32'h00000000, 1'b0, 32'h52525252, "inv_zero", a);
        drain("fwd");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
